// File: rtl/cnn_result_packer.sv
// cnn_result_packer: packs accelerator results into bus words, buffers them and serves bus reads.
// Optional feature: define CNN_PACKER_STATS_EN to add a 32-bit accepted-beat counter behind the TOTAL register.
module cnn_result_packer #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int RESULT_WIDTH   = 32,
    parameter int DEPTH          = 16
) (
    input  logic                      clkIn,
    input  logic                      rstIn,
    input  logic [RESULT_WIDTH-1:0]   dataIn,
    input  logic                      validIn,
    input  logic                      lastIn,
    output logic                      readyOut,
    input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
    input  logic                      rdEnIn,
    output logic [BUS_DATA_WIDTH-1:0] rdDataOut,
    output logic                      rdAckOut,
    output logic                      doneOut
);
    localparam int LANES = BUS_DATA_WIDTH / RESULT_WIDTH;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [BUS_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [LW-1:0]             r_lane;
    logic [BUS_DATA_WIDTH-1:0] r_pack;
    logic                      r_underflow;
    logic                      r_last_seen;
    logic                      r_done;
    logic                      r_rd_ack;
    logic [BUS_DATA_WIDTH-1:0] r_rd_data;

    logic                      w_accept;
    logic                      w_commit;
    logic                      w_empty;
    logic                      w_pop;
    logic [1:0]                w_sel;
    logic [BUS_DATA_WIDTH-1:0] w_word;
    logic [BUS_DATA_WIDTH-1:0] w_status;
    logic [BUS_DATA_WIDTH-1:0] w_total;
    logic [BUS_DATA_WIDTH-1:0] w_rd_data;
    logic                      w_unused_addr;

    assign readyOut  = r_count < CW'(DEPTH);
    assign w_accept  = validIn & readyOut;
    assign w_commit  = w_accept & ((r_lane == LW'(LANES - 1)) | lastIn);
    // Lanes at and above r_lane are still zero in r_pack, so OR-ing in the new beat builds the word.
    assign w_word    = r_pack | (BUS_DATA_WIDTH'(dataIn) << (r_lane * RESULT_WIDTH));
    assign w_sel     = addrIn[4:3];
    assign w_empty   = (r_count == '0);
    assign w_pop     = rdEnIn & (w_sel == 2'd0) & ~w_empty;
    assign w_unused_addr = ^{addrIn[BUS_ADDR_WIDTH-1:5], addrIn[2:0]};

    // Status word: sticky underflow, last-seen flag and current fill level.
    always_comb begin
        w_status        = '0;
        w_status[16]    = r_underflow;
        w_status[15]    = r_last_seen;
        w_status[14:0]  = 15'(r_count);
    end

    assign w_rd_data = (w_sel == 2'd0) ? (w_empty ? '0 : r_mem[r_rd_ptr]) :
                       (w_sel == 2'd1) ? w_status :
                       (w_sel == 2'd2) ? w_total : '0;

`ifdef CNN_PACKER_STATS_EN
    logic [31:0] r_total;
    // Accepted-beat counter; the first beat after done starts a fresh run at 1.
    always_ff @(posedge clkIn) begin
        if (!rstIn)
            r_total <= '0;
        else if (w_accept)
            r_total <= r_done ? 32'd1 : r_total + 32'd1;
    end
    assign w_total = BUS_DATA_WIDTH'(r_total);
`else
    assign w_total = '0;
`endif

    // Buffer storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clkIn) begin
        if (w_commit)
            r_mem[r_wr_ptr] <= w_word;
    end

    // Packing, circular-buffer bookkeeping, bus read response and completion tracking.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
            r_underflow <= 1'b0;
            r_last_seen <= 1'b0;
            r_done      <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_ack  <= rdEnIn;
            r_rd_data <= rdEnIn ? w_rd_data : '0;
            if (w_accept) begin
                r_lane      <= w_commit ? '0 : r_lane + 1'b1;
                r_pack      <= w_commit ? '0 : w_word;
                r_last_seen <= lastIn | (r_last_seen & ~r_done);
            end
            if (w_commit)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_commit != w_pop)
                r_count <= w_commit ? r_count + 1'b1 : r_count - 1'b1;
            if (rdEnIn && w_sel == 2'd0 && w_empty)
                r_underflow <= 1'b1;
            else if (rdEnIn && w_sel == 2'd1)
                r_underflow <= 1'b0;
            r_done <= r_last_seen & w_empty & (r_lane == '0);
        end
    end

    assign rdAckOut  = r_rd_ack;
    assign rdDataOut = r_rd_data;
    assign doneOut   = r_done;
endmodule
